moving_average_checker: RTL
===========================

MOVING_AVERAGE_CHECKER -- requirements
Module: moving_average_checker

Interface
REQ-001 SHALL have parameter WINDOW, default 4, averaging window length; power of two, 2..16.
REQ-002 SHALL have parameter LATENCY, default 1, DUT input-to-output latency in clock cycles, 0..8.
REQ-003 SHALL have parameter MAX_SAMPLES, default 64, number of compared samples per run, 1..255.
REQ-004 SHALL have port system1000  input  1  sole clock, rising edge.
REQ-005 SHALL have port system1000_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse that begins a run.
REQ-007 SHALL have port sample_i  input  8 signed  stimulus sample driven into the DUT this cycle.
REQ-008 SHALL have port dut_o  input  8 signed  DUT moving-average output.
REQ-009 SHALL have port done_o  output  1  run complete; held until the next start_i.
REQ-010 SHALL have port pass_o  output  1  valid when done_o=1; 1 iff err_count_o=0.
REQ-011 SHALL have port err_count_o  output  8  mismatch count, saturating at 255.
REQ-012 SHALL have port first_err_idx_o  output  8  compare index of first mismatch; 0 if none.

Function
REQ-013 SHALL implement FSM IDLE -> FILL -> CHECK -> DONE; start_i in IDLE or DONE SHALL enter FILL; start_i in FILL or CHECK SHALL be ignored.
REQ-014 SHALL, on entering FILL, clear history, err_count_o, first_err_idx_o, done_o and pass_o.
REQ-015 SHALL capture sample_i every cycle in FILL and CHECK into a WINDOW-deep history; the capture cycle of start_i SHALL be history index 0.
REQ-016 SHALL remain in FILL for LATENCY+WINDOW-1 cycles, then enter CHECK.
REQ-017 SHALL compute expected = floor(sum of last WINDOW samples / WINDOW): sum sign-extended to 8+log2(WINDOW) bits, arithmetic shift right by log2(WINDOW), low 8 bits kept.
REQ-018 SHALL delay expected by LATENCY cycles before comparing it with dut_o.
REQ-019 SHALL in CHECK compare once per cycle for MAX_SAMPLES cycles, with compare index counting from 0, then enter DONE.
REQ-020 SHALL on a mismatch increment err_count_o, saturating at 255, and latch first_err_idx_o only on the first mismatch of the run.
REQ-021 SHALL in DONE assert done_o=1 and pass_o=(err_count_o==0); both SHALL be 0 in all other states.
REQ-022 SHALL treat a start_i coinciding with the last CHECK cycle as ignored: the final compare completes and the FSM enters DONE.

Reset
REQ-023 SHALL, on system1000_rstn=0, immediately force IDLE, zero history and delay line, and set done_o=0, pass_o=0, err_count_o=0, first_err_idx_o=0.
REQ-024 SHALL abandon any run in progress on reset; no partial result SHALL survive.
REQ-025 SHALL leave reset synchronously, on the first rising edge after system1000_rstn returns to 1.

Configuration
REQ-026 SHALL, with MA_CHECK_ABORT_EN defined, enter DONE in the cycle after the first mismatch, giving err_count_o=1 and pass_o=0.
REQ-027 SHALL, without MA_CHECK_ABORT_EN, run all MAX_SAMPLES compares regardless of mismatches.

Structure
REQ-028 SHALL place in package ma_check_pkg: the FSM state enum, the sample_t signed-8 typedef and the error-count saturation constant.
REQ-029 SHALL instantiate sub-module ma_delay_line, a parameterised signed shift register, used for both the sample history and the LATENCY alignment.

Verification
REQ-030 SHALL cover WINDOW=4, LATENCY=1, sample_i=8 constant, correct DUT -> done_o=1, pass_o=1, err_count_o=0 after 64 compares.
REQ-031 SHALL cover step input 0,0,0,0,16,16,16,16 -> expected sequence 0,4,8,12,16 and no mismatch from a correct DUT.
REQ-032 SHALL cover negative flooring: window -3,0,0,0 -> expected -1; window -1,-1,-1,-1 -> expected -1.
REQ-033 SHALL cover dut_o corrupted by +1 at compare index 10 only -> err_count_o=1, first_err_idx_o=10, pass_o=0.
REQ-034 SHALL cover reset pulsed at compare index 20 -> all outputs 0 and IDLE in the same cycle; a new start_i then gives a clean pass.
REQ-035 SHALL cover, with MA_CHECK_ABORT_EN defined, a mismatch at compare index 3 -> done_o=1 one cycle later, err_count_o=1.

Source files
------------

// File: rtl/ma_check_pkg.sv
// Shared types and constants for the moving-average checker.
package ma_check_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DONE
  } state_t;

  typedef logic signed [7:0] sample_t;

  localparam logic [7:0] ERR_SAT = 8'd255;

  // Error counter increment that sticks at ERR_SAT.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ma_delay_line.sv
// Signed sample shift register. Tap 0 is the newest sample. A clear loads the
// incoming sample into tap 0 and zeroes the older taps, so the clear cycle is
// itself a capture. DEPTH=0 degenerates to a pass-through on o_data.
module ma_delay_line
  import ma_check_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int TAPS  = (DEPTH > 0) ? DEPTH : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_clr,
  input  sample_t            i_data,
  output sample_t [TAPS-1:0] o_taps,
  output sample_t            o_data
);

  sample_t [TAPS-1:0] r_taps;

  // Shift toward higher index; clear zeroes history but still takes the new sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_taps <= '0;
    end else if (i_en || i_clr) begin
      r_taps[0] <= i_data;
      for (int i = 1; i < TAPS; i++) r_taps[i] <= i_clr ? '0 : r_taps[i-1];
    end
  end

  assign o_taps = r_taps;
  assign o_data = (DEPTH == 0) ? i_data : r_taps[TAPS-1];

endmodule

// File: rtl/moving_average_checker.sv
// Moving-average DUT checker. Captures the stimulus into a WINDOW-deep
// history, forms the floored window average, delays it by LATENCY cycles and
// compares it with the DUT output for MAX_SAMPLES cycles per run.
// Compare index c checks the average of samples c..c+WINDOW-1 of the run.
// Optional: define MA_CHECK_ABORT_EN to stop the run right after the first
// mismatch.
module moving_average_checker
  import ma_check_pkg::*;
#(
  parameter int WINDOW      = 4,
  parameter int LATENCY     = 1,
  parameter int MAX_SAMPLES = 64
) (
  input  logic       system1000,
  input  logic       system1000_rstn,
  input  logic       start_i,
  input  sample_t    sample_i,
  input  sample_t    dut_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_count_o,
  output logic [7:0] first_err_idx_o
);

  localparam int LOG2W = $clog2(WINDOW);
  localparam int SW    = 8 + LOG2W;
  localparam int LTAPS = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [7:0] FILL_LAST  = 8'(LATENCY + WINDOW - 2);
  localparam logic [7:0] CHECK_LAST = 8'(MAX_SAMPLES - 1);

  state_t r_state, w_next;
  logic [7:0] r_cnt, r_err, r_first;
  logic       w_go, w_active, w_mis;
  sample_t [WINDOW-1:0] w_hist;
  sample_t [LTAPS-1:0]  w_dly_taps;
  sample_t    w_hist_old, w_exp, w_exp_d;
  logic signed [SW-1:0] w_sum;
  logic       w_unused;

  assign w_go     = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_active = (r_state == S_FILL) || (r_state == S_CHECK);
  assign w_mis    = (r_state == S_CHECK) && (w_exp_d != dut_o);

  ma_delay_line #(.DEPTH(WINDOW)) u_hist (
    .i_clk   (system1000),
    .i_rst_n (system1000_rstn),
    .i_en    (w_active),
    .i_clr   (w_go),
    .i_data  (sample_i),
    .o_taps  (w_hist),
    .o_data  (w_hist_old)
  );

  // Sign-extended window sum; the arithmetic shift gives floor division.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WINDOW; i++) w_sum = w_sum + {{LOG2W{w_hist[i][7]}}, w_hist[i]};
  end

  assign w_exp = sample_t'(w_sum >>> LOG2W);

  ma_delay_line #(.DEPTH(LATENCY)) u_lat (
    .i_clk   (system1000),
    .i_rst_n (system1000_rstn),
    .i_en    (1'b1),
    .i_clr   (1'b0),
    .i_data  (w_exp),
    .o_taps  (w_dly_taps),
    .o_data  (w_exp_d)
  );

  assign w_unused = ^{w_hist_old, w_dly_taps};

  // Next-state: starts only from IDLE/DONE, FILL is a fixed count, CHECK a fixed compare count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_next = S_FILL;
      S_FILL:         if (r_cnt == FILL_LAST) w_next = S_CHECK;
      S_CHECK: begin
        if (r_cnt == CHECK_LAST) w_next = S_DONE;
`ifdef MA_CHECK_ABORT_EN
        if (w_mis) w_next = S_DONE;
`endif
      end
      default:        w_next = S_IDLE;
    endcase
  end

  // State, phase counter and run results; a new run wipes the previous result.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt   <= '0;
        r_err   <= '0;
        r_first <= '0;
      end else if (r_state == S_FILL) begin
        r_cnt <= (r_cnt == FILL_LAST) ? 8'd0 : r_cnt + 8'd1;
      end else if (r_state == S_CHECK) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_mis) begin
          r_err <= sat_inc(r_err);
          if (r_err == 8'd0) r_first <= r_cnt;
        end
      end
    end
  end

  assign done_o          = (r_state == S_DONE);
  assign pass_o          = done_o && (r_err == 8'd0);
  assign err_count_o     = r_err;
  assign first_err_idx_o = r_first;

endmodule
